// File: rtl/fwd_sel_ctrl_if.sv
// ---------------------------------------------------------------------------
// fwd_sel_ctrl_if
//   ID-stage instruction fields and pipeline controls into the forwarding
//   controller, plus the stall request and EX operand-mux selects back out.
//   master : the pipeline / decode side (drives ID fields, reads selects)
//   slave  : fwd_sel_ctrl
// ---------------------------------------------------------------------------
interface fwd_sel_ctrl_if #(
    parameter int unsigned REG_AW = 5
) ();

    localparam int unsigned SEL_W = 3;

    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_is_load;
    logic              id_use_imm;
    logic              stall_in;
    logic              flush;
    logic              load_stall;
    logic [SEL_W-1:0]  ex_sel_a;
    logic [SEL_W-1:0]  ex_sel_b;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_reg_write, id_is_load,
               id_use_imm, stall_in, flush,
        input  load_stall, ex_sel_a, ex_sel_b
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_reg_write, id_is_load,
               id_use_imm, stall_in, flush,
        output load_stall, ex_sel_a, ex_sel_b
    );

endinterface : fwd_sel_ctrl_if

// File: rtl/fwd_sel_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_sel_ctrl
//   Operand-forwarding controller for the five-stage pipeline. Tracks the
//   destination register of the instructions in EX and MEM, computes the
//   EX operand-mux selects while the consumer is in ID, and raises a
//   combinational load-use stall request.
//   clk        : clock, rising edge
//   rst        : asynchronous, active-high reset
//   bus.slave  : ID fields, stall_in/flush in; load_stall (comb),
//                ex_sel_a / ex_sel_b (registered) out
//   Select codes: 000 regfile, 001 EX/MEM ALU, 010 MEM/WB ALU,
//                 011 MEM/WB load data, 100 immediate (B only)
// ---------------------------------------------------------------------------
module fwd_sel_ctrl #(
    parameter int unsigned REG_AW = 5
) (
    input  logic           clk,
    input  logic           rst,
    fwd_sel_ctrl_if.slave  bus
);

    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_RF     = 3'b000;
    localparam logic [SEL_W-1:0] SEL_EX_ALU = 3'b001;
    localparam logic [SEL_W-1:0] SEL_WB_ALU = 3'b010;
    localparam logic [SEL_W-1:0] SEL_WB_LD  = 3'b011;
    localparam logic [SEL_W-1:0] SEL_IMM    = 3'b100;

    // One in-flight instruction as seen by the forwarding logic
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              is_load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: '0, reg_write: 1'b0, is_load: 1'b0};

    slot_t            ex_q,    ex_d;
    slot_t            mem_q,   mem_d;
    logic [SEL_W-1:0] sel_a_q, sel_a_d;
    logic [SEL_W-1:0] sel_b_q, sel_b_d;

    logic [SEL_W-1:0] id_sel_a;
    logic [SEL_W-1:0] id_sel_b;
    logic             stall_req;
    slot_t            id_slot;

    // True when slot s will write register r; $0 never counts as a result
    function automatic logic is_writer(input slot_t s, input logic [REG_AW-1:0] r);
        return s.valid && s.reg_write && (s.rd == r) && (r != '0);
    endfunction

    // Nearest producer wins: EX beats MEM, otherwise fall back to regfile
    function automatic logic [SEL_W-1:0] fwd_code(input slot_t ex,
                                                  input slot_t mem,
                                                  input logic [REG_AW-1:0] r);
        logic [SEL_W-1:0] code;
        code = SEL_RF;
        if (is_writer(ex, r)) begin
            code = SEL_EX_ALU;
        end else if (is_writer(mem, r)) begin
            code = mem.is_load ? SEL_WB_LD : SEL_WB_ALU;
        end
        return code;
    endfunction

    // Load-use hazard: a load in EX produces data too late for the ID consumer
    always_comb begin
        stall_req = 1'b0;
        if (bus.id_valid && ex_q.is_load && is_writer(ex_q, ex_q.rd)) begin
            stall_req = (ex_q.rd == bus.id_rs) ||
                        ((ex_q.rd == bus.id_rt) && !bus.id_use_imm);
        end
    end

    // Select codes for the instruction currently in ID
    always_comb begin
        id_sel_a = fwd_code(ex_q, mem_q, bus.id_rs);
        id_sel_b = bus.id_use_imm ? SEL_IMM : fwd_code(ex_q, mem_q, bus.id_rt);
    end

    // ID fields packed into a slot; a non-valid ID leaves an empty slot
    always_comb begin
        id_slot = SLOT_EMPTY;
        if (bus.id_valid) begin
            id_slot.valid     = 1'b1;
            id_slot.rd        = bus.id_rd;
            id_slot.reg_write = bus.id_reg_write;
            id_slot.is_load   = bus.id_is_load;
        end
    end

    // Slot advance: freeze > flush/load-use bubble > normal issue into EX
    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;
        if (bus.stall_in) begin
            ex_d    = ex_q;
            mem_d   = mem_q;
        end else if (bus.flush || stall_req) begin
            ex_d    = SLOT_EMPTY;
            mem_d   = ex_q;
            sel_a_d = SEL_RF;
            sel_b_d = SEL_RF;
        end else begin
            ex_d    = id_slot;
            mem_d   = ex_q;
            sel_a_d = bus.id_valid ? id_sel_a : SEL_RF;
            sel_b_d = bus.id_valid ? id_sel_b : SEL_RF;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= SLOT_EMPTY;
            mem_q   <= SLOT_EMPTY;
            sel_a_q <= SEL_RF;
            sel_b_q <= SEL_RF;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign bus.load_stall = stall_req;
    assign bus.ex_sel_a   = sel_a_q;
    assign bus.ex_sel_b   = sel_b_q;

endmodule : fwd_sel_ctrl

// File: tb/tb_fwd_sel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwd_sel_ctrl
//   Scoreboard bench for fwd_sel_ctrl. The driver keeps a history of the
//   instructions occupying the stages after ID (youngest first) and derives
//   the expected selects by scanning it for the nearest producer; the
//   monitor pops those expectations after every rising edge.
// ---------------------------------------------------------------------------
module tb_fwd_sel_ctrl;

    localparam int unsigned REG_AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fwd_sel_ctrl_if #(.REG_AW(REG_AW)) bus ();

    fwd_sel_ctrl #(.REG_AW(REG_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit ld;
    } ins_t;

    typedef struct {
        int a;
        int b;
    } exp_t;

    ins_t hist[$];      // instructions past ID, index 0 = youngest
    exp_t sbq[$];       // expected selects after the next edge
    int   last_a = 0;
    int   last_b = 0;
    int   errors = 0;
    int   checks = 0;
    bit   last_stall;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit writes(input ins_t i, input int r);
        return i.v && i.rw && (i.rd == r) && (r != 0);
    endfunction

    // Distance to the nearest older producer decides the code
    function automatic int fwd(input int r);
        for (int d = 0; d < hist.size(); d++) begin
            if (writes(hist[d], r)) begin
                if (d == 0) return 1;
                return hist[d].ld ? 3 : 2;
            end
        end
        return 0;
    endfunction

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("ex_sel_a", int'(bus.ex_sel_a), e.a);
                check("ex_sel_b", int'(bus.ex_sel_b), e.b);
            end
        end
    end

    // One ID cycle: drive at negedge, check stall, predict, return after edge
    task automatic issue(input bit v, input int rs, input int rt, input int rd,
                         input bit rw, input bit ld, input bit imm,
                         input bit st, input bit fl);
        bit   exp_stall;
        ins_t n;
        exp_t e;
        @(negedge clk);
        bus.id_valid     = v;
        bus.id_rs        = REG_AW'(rs);
        bus.id_rt        = REG_AW'(rt);
        bus.id_rd        = REG_AW'(rd);
        bus.id_reg_write = rw;
        bus.id_is_load   = ld;
        bus.id_use_imm   = imm;
        bus.stall_in     = st;
        bus.flush        = fl;
        #1;
        exp_stall = 1'b0;
        if (v && hist.size() > 0 && hist[0].ld && writes(hist[0], hist[0].rd))
            exp_stall = (hist[0].rd == rs) || (hist[0].rd == rt && !imm);
        last_stall = bus.load_stall;
        check("load_stall", int'(bus.load_stall), int'(exp_stall));
        if (!st) begin
            if (fl || exp_stall || !v) begin
                n = '{v: 1'b0, rd: 0, rw: 1'b0, ld: 1'b0};
                last_a = 0;
                last_b = 0;
            end else begin
                n = '{v: 1'b1, rd: rd, rw: rw, ld: ld};
                last_a = fwd(rs);
                last_b = imm ? 4 : fwd(rt);
            end
            hist.push_front(n);
            if (hist.size() > 2) void'(hist.pop_back());
        end
        e = '{a: last_a, b: last_b};
        sbq.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Reset asserted between edges, checked immediately, released after an edge
    task automatic async_reset();
        exp_t e;
        rst = 1'b1;
        #1;
        check("rst_load_stall", int'(bus.load_stall), 0);
        check("rst_sel_a", int'(bus.ex_sel_a), 0);
        check("rst_sel_b", int'(bus.ex_sel_b), 0);
        hist.delete();
        last_a = 0;
        last_b = 0;
        e = '{a: 0, b: 0};
        sbq.push_back(e);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic chk_sel(input string name, input int a, input int b);
        check({name, "_a"}, int'(bus.ex_sel_a), a);
        check({name, "_b"}, int'(bus.ex_sel_b), b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.id_valid = 0; bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
        bus.id_reg_write = 0; bus.id_is_load = 0; bus.id_use_imm = 0;
        bus.stall_in = 0; bus.flush = 0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_stall", int'(bus.load_stall), 0);
        chk_sel("reset", 0, 0);
        rst = 1'b0;

        // Adjacent ALU forward
        issue(1, 1, 2, 3, 1, 0, 0, 0, 0);
        issue(1, 3, 4, 10, 0, 0, 0, 0, 0);
        check("adj_stall", int'(last_stall), 0);
        chk_sel("adj", 1, 0);

        // Two-back ALU forward, then nearer writer override
        issue(1, 1, 2, 5, 1, 0, 0, 0, 0);
        issue(1, 1, 2, 6, 1, 0, 0, 0, 0);
        issue(1, 5, 2, 10, 0, 0, 0, 0, 0);
        chk_sel("two_back", 2, 0);
        issue(1, 1, 2, 5, 1, 0, 0, 0, 0);
        issue(1, 1, 2, 5, 1, 0, 0, 0, 0);
        issue(1, 5, 2, 10, 0, 0, 0, 0, 0);
        chk_sel("nearer", 1, 0);

        // Load-use: one bubble then load data
        issue(1, 1, 2, 7, 1, 1, 0, 0, 0);
        issue(1, 1, 7, 10, 0, 0, 0, 0, 0);
        check("lu_stall", int'(last_stall), 1);
        chk_sel("lu_bubble", 0, 0);
        issue(1, 1, 7, 10, 0, 0, 0, 0, 0);
        check("lu_stall_once", int'(last_stall), 0);
        chk_sel("lu_fwd", 0, 3);
        issue(1, 1, 2, 7, 1, 1, 0, 0, 0);
        issue(1, 2, 7, 10, 0, 0, 1, 0, 0);
        check("lu_imm_stall", int'(last_stall), 0);
        chk_sel("lu_imm", 0, 4);

        // Register zero
        issue(1, 1, 2, 0, 1, 0, 0, 0, 0);
        issue(1, 0, 2, 10, 0, 0, 0, 0, 0);
        chk_sel("r0_alu", 0, 0);
        issue(1, 1, 2, 0, 1, 1, 0, 0, 0);
        issue(1, 0, 0, 10, 0, 0, 0, 0, 0);
        check("r0_stall", int'(last_stall), 0);
        chk_sel("r0_load", 0, 0);

        // Freeze for three cycles with a live forward
        issue(1, 1, 2, 8, 1, 0, 0, 0, 0);
        issue(1, 8, 2, 10, 0, 0, 0, 0, 0);
        chk_sel("pre_freeze", 1, 0);
        for (int i = 0; i < 3; i++) begin
            issue(1, 3, 3, 3, 1, 1, 0, 1, 0);
            chk_sel("freeze", 1, 0);
        end
        issue(1, 8, 2, 10, 0, 0, 0, 0, 0);
        chk_sel("post_freeze", 2, 0);

        // Flush bubble; the writer still forwards from MEM
        issue(1, 1, 2, 9, 1, 0, 0, 0, 0);
        issue(1, 9, 9, 10, 0, 0, 0, 0, 1);
        chk_sel("flush_bubble", 0, 0);
        issue(1, 9, 2, 10, 0, 0, 0, 0, 0);
        chk_sel("flush_fwd", 2, 0);

        // Asynchronous reset with a load in EX and load_stall high
        issue(1, 1, 2, 7, 1, 1, 0, 0, 0);
        @(negedge clk);
        bus.id_valid = 1; bus.id_rs = REG_AW'(7); bus.id_rt = REG_AW'(2);
        bus.id_rd = REG_AW'(10); bus.id_reg_write = 0; bus.id_is_load = 0;
        bus.id_use_imm = 0; bus.stall_in = 0; bus.flush = 0;
        #1;
        check("pre_rst_stall", int'(bus.load_stall), 1);
        async_reset();
        issue(1, 7, 7, 10, 0, 0, 0, 0, 0);
        check("post_rst_stall", int'(last_stall), 0);
        chk_sel("post_rst", 0, 0);

        // Randomized traffic on a small register set to provoke hazards
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(99) == 0) begin
                @(negedge clk);
                #3;
                async_reset();
            end else begin
                issue($urandom_range(99) < 85,
                      int'($urandom_range(3)), int'($urandom_range(3)),
                      int'($urandom_range(3)),
                      $urandom_range(99) < 70, $urandom_range(99) < 30,
                      $urandom_range(99) < 25,
                      $urandom_range(99) < 10, $urandom_range(99) < 10);
            end
        end

        check("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fwd_sel_ctrl

// File: doc/fwd_sel_ctrl.md
# fwd_sel_ctrl

Operand-forwarding controller for the five-stage pipeline: it tracks the destination register of every in-flight instruction and produces the registered 3-bit select codes that drive the EX-stage 5-input operand muxes (A and B). It also detects load-use hazards and requests a one-cycle ID stall. The block sits beside the ID/EX pipeline register and shares its stall and flush controls.

## Interface
- REG_AW, 5, register-address width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  ID source registers
- id_rd  in  REG_AW  ID destination register, already resolved between rd and rt
- id_reg_write  in  1  ID instruction writes the register file
- id_is_load  in  1  ID instruction is a load
- id_use_imm  in  1  operand B is the immediate
- stall_in  in  1  global freeze, for example a memory wait
- flush  in  1  squash the ID instruction; a branch resolved in EX
- load_stall  out  1  combinational; freeze IF/ID and insert an EX bubble
- ex_sel_a, ex_sel_b  out  3  registered mux selects for the instruction in EX

## Operation
- Select codes:
  - 000: register-file value
  - 001: EX/MEM ALU result
  - 010: MEM/WB ALU result
  - 011: MEM/WB load data
  - 100: immediate (ex_sel_b only)
  - ex_sel_a never takes 100. Codes 101–111 are never produced.
- Internal slots: EX and MEM, each holding valid, rd, reg_write and is_load.
- Writer condition: a slot is a writer for register r when valid, reg_write, rd == r, and r != 0.
- Select computation, done in ID for each source r (rs for A, rt for B):
  - If the EX slot is a writer for r, the code is 001. That instruction reaches MEM next cycle.
  - Otherwise, if the MEM slot is a writer for r, the code is 011 when the slot's is_load is set, else 010.
  - Otherwise the code is 000.
  - For B, id_use_imm overrides everything with 100.
  - Nearest producer wins.
- Register-file writes in WB are visible to same-cycle ID reads (write-first register file), so no WB-stage code is needed.
- Load-use hazard:
  - load_stall = id_valid & EX slot valid & EX is_load & EX reg_write & EX rd != 0 & (EX rd == id_rs | (EX rd == id_rt & !id_use_imm)).
  - load_stall is not gated by flush or stall_in. The surrounding pipeline decides whether to use it.
- Slot update priority on each edge:
  1. stall_in: every slot and both sel outputs hold.
  2. flush: the EX slot gets a bubble (valid=0, sels 000); the MEM slot gets the old EX contents.
  3. load_stall: same bubble insertion as flush; the ID instruction is re-evaluated next cycle.
  4. Normal: the EX slot gets the ID fields (valid = id_valid) and the computed sels; the MEM slot gets the old EX contents.
- Whenever the EX slot is loaded with id_valid = 0 or with a bubble, the sels are 000.

## Timing
- Reset values: all slots invalid, ex_sel_a = ex_sel_b = 000, load_stall = 0 (no valid EX slot).
- Reset may be asserted mid-stream; it clears all slots immediately, with no pending forwards afterwards.
- Latency: sels computed in ID appear on ex_sel_* one edge later and align with the instruction in EX.
- load_stall is combinational from the ID inputs and the EX slot, in the same cycle.
- Stall length: a load-use stall lasts exactly one cycle. After the bubble, the load is in MEM and the dependent instruction gets 011.
- Back-to-back writers of the same register: the younger one (EX slot) wins with 001.
- Register $0 is never forwarded and never stalls.

## Test plan
- Forward from the adjacent instruction:
  - Stimulus: ADD r3 (rd=3, reg_write) issued, then the next ID has rs=3, rt=4.
  - Required: load_stall=0; one edge later ex_sel_a=001, ex_sel_b=000.
- Two-back ALU forward, with override from the nearer writer:
  - Stimulus: writer rd=5, an unrelated instruction, then a reader rs=5.
  - Required: ex_sel_a=010.
  - Repeat with the middle instruction also writing rd=5; required ex_sel_a=001.
- Load-use:
  - Stimulus: LW rd=7, then a reader rt=7 with id_use_imm=0.
  - Required: load_stall=1 for exactly one cycle; the next edge gives sels 000 (bubble); the following edge gives ex_sel_b=011.
  - Repeat with id_use_imm=1 and rs≠7; required: no stall, ex_sel_b=100.
- Register zero:
  - Stimulus: writer rd=0, then a reader rs=0, including the case where the writer is a load.
  - Required: ex_sel_a=000, load_stall=0.
- Stall and flush:
  - stall_in held 3 cycles while ex_sel_a=001; required: the outputs and forwarding state are frozen.
  - Writer rd=9 followed by a flush in the cycle its dependent would enter EX; required: the bubble gives sels 000, and the writer still forwards 010 to the next reader of r9.
- Asynchronous reset:
  - Stimulus: rst asserted between edges with a load in the EX slot and load_stall=1.
  - Required: load_stall=0 and sels=000 immediately. After release, a reader of the old rd gets 000.
